// File: rtl/riscv_cpu_dmem_responder.sv
// riscv_cpu_dmem_responder: data-memory slave with req/gnt/rvalid handshake, wait states and byte-lane steering
module riscv_cpu_dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_we, r_err;
  logic [2:0]            r_f3;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic                  w_idle, w_go, w_we, w_err, w_wr;
  logic [2:0]            w_f3;
  logic [31:0]           w_addr;
  logic [DATA_WIDTH-1:0] w_wdata, w_word, w_load, w_wdat;
  logic [ADDR_BITS-1:0]  w_idx;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_be;
  // With zero wait states the response edge is the grant edge, so decode straight from the inputs
  always_comb begin
    w_idle  = r_state == S_IDLE;
    gnt_o   = rst_n & req_i & w_idle;
    w_we    = w_idle ? we_i : r_we;
    w_f3    = w_idle ? funct3_i : r_f3;
    w_addr  = w_idle ? addr_i : r_addr;
    w_wdata = w_idle ? wdata_i : r_wdata;
    w_go    = (gnt_o & (WS == 4'd0)) | (r_state == S_WAIT & r_cnt == WS);
    w_err   = (w_f3[1:0] == 2'b01 & w_addr[0]) | (w_f3[1:0] == 2'b10 & w_addr[1:0] != 2'b00)
            | (w_we ? w_f3 >= 3'b011 : (w_f3 == 3'b011 | w_f3[2:1] == 2'b11))
            | (w_addr[31:ADDR_BITS+2] != '0);
    w_idx   = w_addr[ADDR_BITS+1:2];
    w_word  = r_mem[w_idx];
    w_byte  = w_word[{w_addr[1:0], 3'b000} +: 8];
    w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load  = w_f3 == 3'b000 ? {{24{w_byte[7]}}, w_byte}
            : w_f3 == 3'b001 ? {{16{w_half[15]}}, w_half}
            : w_f3 == 3'b100 ? {24'd0, w_byte}
            : w_f3 == 3'b101 ? {16'd0, w_half} : w_word;
    w_wdat  = w_f3[1:0] == 2'b00 ? {4{w_wdata[7:0]}} : w_f3[1:0] == 2'b01 ? {2{w_wdata[15:0]}} : w_wdata;
    w_be    = w_f3[1:0] == 2'b00 ? 4'b0001 << w_addr[1:0]
            : w_f3[1:0] == 2'b01 ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wr    = rst_n & w_go & w_we & ~w_err;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (gnt_o) begin
        r_we    <= we_i;
        r_f3    <= funct3_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
      r_state <= w_go ? S_RESP : gnt_o ? S_WAIT : r_state == S_RESP ? S_IDLE : r_state;
      r_cnt   <= gnt_o ? 4'd1 : (r_state == S_WAIT & ~w_go) ? r_cnt + 4'd1 : 4'd0;
      if (w_go) begin
        r_err   <= w_err;
        r_rdata <= (w_we | w_err) ? '0 : w_load;
      end
    end
  end
  always_ff @(posedge clk)
    if (w_wr)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
  assign rvalid_o = r_state == S_RESP;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
endmodule

// File: tb/tb_riscv_cpu_dmem_responder.sv
// tb_riscv_cpu_dmem_responder: directed checks of the data-memory responder with 1 and 0 wait states
module tb_riscv_cpu_dmem_responder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req [2], we [2], gnt [2], rv [2], er [2];
  logic [2:0]  f3 [2];
  logic [31:0] ad [2], wd [2], rdat [2];
  int          vecs = 0, fails = 0;
  logic [31:0] rd;
  logic        e;
  int          lat;
  always #5 clk = ~clk;
  riscv_cpu_dmem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .funct3_i(f3[0]), .addr_i(ad[0]),
    .wdata_i(wd[0]), .gnt_o(gnt[0]), .rvalid_o(rv[0]), .rdata_o(rdat[0]), .err_o(er[0]));
  riscv_cpu_dmem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .funct3_i(f3[1]), .addr_i(ad[1]),
    .wdata_i(wd[1]), .gnt_o(gnt[1]), .rvalid_o(rv[1]), .rdata_o(rdat[1]), .err_o(er[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Returns the number of falling edges from the grant sample to the rvalid sample, -1 on timeout
  task automatic access(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wdat, output logic [31:0] r, output logic x, output int l);
    int n = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; f3[d] = f; ad[d] = a; wd[d] = wdat;
    l = -1; r = 'x; x = 1'bx;
    while (!gnt[d] && n < 20) begin @(negedge clk); n++; end
    if (!gnt[d]) begin req[d] = 1'b0; return; end
    @(posedge clk); #1 req[d] = 1'b0;
    for (int k = 1; k <= 20 && l < 0; k++) begin
      @(negedge clk);
      if (rv[d]) begin l = k; r = rdat[d]; x = er[d]; end
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin req[i] = 1'b0; we[i] = 1'b0; f3[i] = 3'd0; ad[i] = 0; wd[i] = 0; end
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt[0], 0);
    chk("rst_rvalid", rv[0], 0);
    chk("rst_err", er[0], 0);
    chk("rst_rdata", rdat[0], 0);
    rst_n = 1'b1; req[0] = 1'b0;
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat);
    chk("sw_err", e, 0); chk("sw_rdata", rd, 0); chk("sw_lat", lat, 2);
    access(0, 0, 3'b010, 32'h10, 0, rd, e, lat);
    chk("lw_data", rd, 32'hDEADBEEF); chk("lw_err", e, 0); chk("lw_lat", lat, 2);
    access(0, 1, 3'b000, 32'h13, 32'h80, rd, e, lat);
    chk("sb_err", e, 0);
    access(0, 0, 3'b000, 32'h13, 0, rd, e, lat); chk("lb", rd, 32'hFFFFFF80);
    access(0, 0, 3'b100, 32'h13, 0, rd, e, lat); chk("lbu", rd, 32'h00000080);
    access(0, 0, 3'b010, 32'h10, 0, rd, e, lat); chk("lw_after_sb", rd, 32'h80ADBEEF);
    access(0, 1, 3'b001, 32'h12, 32'h8001, rd, e, lat);
    chk("sh_err", e, 0);
    access(0, 0, 3'b001, 32'h12, 0, rd, e, lat); chk("lh", rd, 32'hFFFF8001);
    access(0, 0, 3'b101, 32'h12, 0, rd, e, lat); chk("lhu", rd, 32'h00008001);
    access(0, 0, 3'b010, 32'h10, 0, rd, e, lat); chk("lw_after_sh", rd, 32'h8001BEEF);
    access(0, 0, 3'b000, 32'h11, 0, rd, e, lat); chk("lb_odd", rd, 32'hFFFFFFBE);
    access(0, 0, 3'b010, 32'h11, 0, rd, e, lat);
    chk("lw_mis_err", e, 1); chk("lw_mis_rdata", rd, 0);
    access(0, 0, 3'b001, 32'h13, 0, rd, e, lat); chk("lh_mis_err", e, 1);
    access(0, 1, 3'b010, 32'h20, 32'h12345678, rd, e, lat); chk("sw20_err", e, 0);
    access(0, 1, 3'b010, 32'h22, 32'h1, rd, e, lat); chk("sw_mis_err", e, 1);
    access(0, 1, 3'b011, 32'h20, 32'h1, rd, e, lat); chk("st_f3_err", e, 1);
    access(0, 0, 3'b010, 32'h20, 0, rd, e, lat); chk("lw20_kept", rd, 32'h12345678);
    access(0, 0, 3'b011, 32'h20, 0, rd, e, lat);
    chk("ld_f3_err", e, 1); chk("ld_f3_rdata", rd, 0);
    access(0, 0, 3'b010, 32'h1000, 0, rd, e, lat); chk("lw_oor_err", e, 1);
    access(0, 1, 3'b010, 32'h1010, 32'h5, rd, e, lat); chk("sw_oor_err", e, 1);
    access(0, 0, 3'b010, 32'h10, 0, rd, e, lat); chk("lw_oor_no_alias", rd, 32'h8001BEEF);
    access(0, 0, 3'b010, 32'hFFC, 0, rd, e, lat); chk("lw_top_err", e, 0);
    access(1, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat);
    chk("ws0_sw_err", e, 0); chk("ws0_sw_lat", lat, 1);
    access(1, 0, 3'b010, 32'h10, 0, rd, e, lat);
    chk("ws0_lw_data", rd, 32'hDEADBEEF); chk("ws0_lw_lat", lat, 1);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; f3[0] = 3'b010; ad[0] = 32'h10;
    #1 chk("bp_gnt_idle", gnt[0], 1);
    @(negedge clk); chk("bp_gnt_wait", gnt[0], 0);
    @(negedge clk); chk("bp_gnt_resp", gnt[0], 0); chk("bp_rvalid", rv[0], 1);
    @(negedge clk); chk("bp_gnt_again", gnt[0], 1);
    @(posedge clk); #1 req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_rvalid2", rv[0], 1); chk("bp_rdata2", rdat[0], 32'h8001BEEF);
    access(0, 1, 3'b010, 32'h30, 32'hAAAA5555, rd, e, lat); chk("sw30_err", e, 0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h30; wd[0] = 32'h11111111;
    #1 chk("rst_mid_gnt", gnt[0], 1);
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); chk("rst_mid_rvalid", rv[0], 0);
    rst_n = 1'b1;
    @(negedge clk); chk("rst_mid_rvalid2", rv[0], 0);
    access(0, 0, 3'b010, 32'h30, 0, rd, e, lat); chk("rst_mid_kept", rd, 32'hAAAA5555);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
